// File: rtl/instr_encoder.sv
// ---------------------------------------------------------------------------
// instr_encoder
//
// Purpose:
//    Program loader placed in front of Instr_Memory. It accepts decoded
//    instruction fields (class, registers, immediate), packs them into 32-bit
//    MIPS words, queues the words in a small FIFO, and writes them out to
//    consecutive word addresses of the instruction memory.
//
// Parameters:
//    DEPTH     - FIFO entries (power of 2, at least 2)
//    ADDR_W    - width of the byte address driven to instruction memory
//    BASE_ADDR - first byte address written after reset or clear (multiple of 4)
//
// Ports:
//    clk_i        in   clock, rising edge
//    rst_i        in   asynchronous reset, active low
//    clear_i      in   synchronous flush: FIFO, address, count and err
//    req_valid_i  in   request field bundle valid
//    req_ready_o  out  encoder can accept a request this cycle
//    op_sel_i     in   class: 0 R, 1 ADDI, 2 ORI, 3 BNE, 4 BEQ, 5 SLTI, 6 LUI, 7 illegal
//    rs_i, rt_i, rd_i, shamt_i, funct_i, imm_i   in   instruction fields
//    im_ready_i   in   memory accepts the write this cycle
//    im_we_o      out  write request (FIFO not empty)
//    im_addr_o    out  byte address of the current write
//    im_data_o    out  encoded word at the FIFO head (zero when empty)
//    count_o      out  words written since reset or clear, saturating
//    err_o        out  sticky illegal-request flag
//    full_o       out  FIFO full
//    empty_o      out  FIFO empty
//
// Optional feature:
//    INSTR_ENC_FUNCT_CHECK_EN - when defined, R-type requests whose funct is
//    not add/sub/and/or/slt are rejected as illegal instead of encoded.
// ---------------------------------------------------------------------------
module instr_encoder #(
   parameter int DEPTH     = 4,
   parameter int ADDR_W    = 10,
   parameter int BASE_ADDR = 0
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              clear_i,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic [2:0]        op_sel_i,
   input  logic [4:0]        rs_i,
   input  logic [4:0]        rt_i,
   input  logic [4:0]        rd_i,
   input  logic [4:0]        shamt_i,
   input  logic [5:0]        funct_i,
   input  logic [15:0]       imm_i,
   input  logic              im_ready_i,
   output logic              im_we_o,
   output logic [ADDR_W-1:0] im_addr_o,
   output logic [31:0]       im_data_o,
   output logic [15:0]       count_o,
   output logic              err_o,
   output logic              full_o,
   output logic              empty_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0]  PTR_ONE   = (PTR_W + 1)'(1);
   localparam logic [ADDR_W-1:0] ADDR_BASE = ADDR_W'(BASE_ADDR);
   localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(4);

   logic [31:0]    fifo_mem [DEPTH];
   logic [PTR_W:0] wr_ptr;
   logic [PTR_W:0] rd_ptr;
   logic           full;
   logic           empty;
   logic           accept;
   logic           illegal;
   logic           push;
   logic           pop;
   logic           funct_ok;
   logic [5:0]     opcode;
   logic [31:0]    enc_word;

   // Opcode lookup and word packing. LUI has no source register, so its
   // rs field is forced to zero whatever the requester drove.
   always_comb begin
      opcode   = 6'h00;
      enc_word = 32'h0;
      case (op_sel_i)
         3'd1:    opcode = 6'h08;
         3'd2:    opcode = 6'h0D;
         3'd3:    opcode = 6'h05;
         3'd4:    opcode = 6'h04;
         3'd5:    opcode = 6'h0A;
         3'd6:    opcode = 6'h0F;
         default: opcode = 6'h00;
      endcase
      if (op_sel_i == 3'd0) begin
         enc_word = {6'h00, rs_i, rt_i, rd_i, shamt_i, funct_i};
      end else if (op_sel_i == 3'd6) begin
         enc_word = {opcode, 5'd0, rt_i, imm_i};
      end else begin
         enc_word = {opcode, rs_i, rt_i, imm_i};
      end
   end

`ifdef INSTR_ENC_FUNCT_CHECK_EN
   // Only the ALU functions the target core implements are allowed through.
   always_comb begin
      funct_ok = 1'b0;
      case (funct_i)
         6'h20, 6'h22, 6'h24, 6'h25, 6'h2A: funct_ok = 1'b1;
         default:                           funct_ok = 1'b0;
      endcase
   end
`else
   assign funct_ok = 1'b1;
`endif

   // Pointers carry one extra wrap bit so full and empty can be told apart
   // when the index bits coincide.
   assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                    (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
   assign empty   = (wr_ptr == rd_ptr);
   assign full_o  = full;
   assign empty_o = empty;

   assign req_ready_o = !full && !clear_i;
   assign illegal     = (op_sel_i == 3'd7) || ((op_sel_i == 3'd0) && !funct_ok);
   assign accept      = req_valid_i && req_ready_o;
   assign push        = accept && !illegal;
   // A clear on the same edge wins, so the pending write is not counted.
   assign pop         = im_we_o && im_ready_i && !clear_i;

   assign im_we_o   = !empty;
   assign im_data_o = empty ? 32'h0 : fifo_mem[rd_ptr[PTR_W-1:0]];

   // Storage needs no reset: reset and clear only move the pointers, which
   // makes any stale contents unreachable.
   always_ff @(posedge clk_i) begin
      if (push) begin
         fifo_mem[wr_ptr[PTR_W-1:0]] <= enc_word;
      end
   end

   // Pointers, write address, write count and the sticky error flag.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         im_addr_o <= ADDR_BASE;
         count_o   <= 16'h0;
         err_o     <= 1'b0;
      end else if (clear_i) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         im_addr_o <= ADDR_BASE;
         count_o   <= 16'h0;
         err_o     <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (pop) begin
            rd_ptr    <= rd_ptr + PTR_ONE;
            im_addr_o <= im_addr_o + ADDR_STEP;
            if (count_o != 16'hFFFF) begin
               count_o <= count_o + 16'd1;
            end
         end
         if (accept && illegal) begin
            err_o <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_instr_encoder.sv
// ---------------------------------------------------------------------------
// tb_instr_encoder
//
// Drives two encoders with identical stimulus: one with the default 10-bit
// address, one with a 4-bit address so the write address wraps quickly.
// A queue-based reference model tracks which words should be waiting, how
// many have been written and whether an illegal request was seen.
// ---------------------------------------------------------------------------
module tb_instr_encoder;

   localparam int DEPTH = 4;

   localparam logic [5:0] OPC [8] = '{6'h00, 6'h08, 6'h0D, 6'h05,
                                      6'h04, 6'h0A, 6'h0F, 6'h00};
   localparam logic [5:0] LEGAL_FN [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};

   typedef struct {
      bit          valid;
      logic [2:0]  op;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
      logic [4:0]  sh;
      logic [5:0]  fn;
      logic [15:0] imm;
      bit          rdy;
      bit          clr;
      bit          e_we;
      logic [9:0]  e_addr;
      logic [31:0] e_data;
      logic [15:0] e_cnt;
      bit          e_err;
      bit          e_full;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        clear;
   logic        req_valid;
   logic [2:0]  op_sel;
   logic [4:0]  rs, rt, rd, shamt;
   logic [5:0]  funct;
   logic [15:0] imm;
   logic        im_ready;

   logic        req_ready, im_we, err, full, empty;
   logic [9:0]  im_addr;
   logic [31:0] im_data;
   logic [15:0] count;

   logic        s_req_ready, s_im_we, s_err, s_full, s_empty;
   logic [3:0]  s_im_addr;
   logic [31:0] s_im_data;
   logic [15:0] s_count;

   logic [31:0] m_q [$];
   int          m_writes;
   logic [15:0] m_count;
   logic        m_err;

   int vectors = 0;
   int miscompares = 0;
   bit cur_bad;

   vec_t tbl [16];

   always #5 clk = ~clk;

   instr_encoder #(.DEPTH(DEPTH), .ADDR_W(10), .BASE_ADDR(0)) dut (
      .clk_i(clk), .rst_i(rst_n), .clear_i(clear),
      .req_valid_i(req_valid), .req_ready_o(req_ready), .op_sel_i(op_sel),
      .rs_i(rs), .rt_i(rt), .rd_i(rd), .shamt_i(shamt), .funct_i(funct),
      .imm_i(imm), .im_ready_i(im_ready), .im_we_o(im_we),
      .im_addr_o(im_addr), .im_data_o(im_data), .count_o(count),
      .err_o(err), .full_o(full), .empty_o(empty)
   );

   instr_encoder #(.DEPTH(DEPTH), .ADDR_W(4), .BASE_ADDR(0)) dut_small (
      .clk_i(clk), .rst_i(rst_n), .clear_i(clear),
      .req_valid_i(req_valid), .req_ready_o(s_req_ready), .op_sel_i(op_sel),
      .rs_i(rs), .rt_i(rt), .rd_i(rd), .shamt_i(shamt), .funct_i(funct),
      .imm_i(imm), .im_ready_i(im_ready), .im_we_o(s_im_we),
      .im_addr_o(s_im_addr), .im_data_o(s_im_data), .count_o(s_count),
      .err_o(s_err), .full_o(s_full), .empty_o(s_empty)
   );

   // Word layout straight from the instruction formats.
   function automatic logic [31:0] ref_word(input logic [2:0] op,
                                            input logic [4:0] f_rs, input logic [4:0] f_rt,
                                            input logic [4:0] f_rd, input logic [4:0] f_sh,
                                            input logic [5:0] f_fn, input logic [15:0] f_imm);
      logic [31:0] w;
      if (op == 3'd0) begin
         w = 32'(f_rs) * (2 ** 21) + 32'(f_rt) * (2 ** 16) + 32'(f_rd) * (2 ** 11)
             + 32'(f_sh) * (2 ** 6) + 32'(f_fn);
      end else begin
         w = 32'(OPC[op]) * (2 ** 26) + 32'(f_rt) * (2 ** 16) + 32'(f_imm);
         if (op != 3'd6) w = w + 32'(f_rs) * (2 ** 21);
      end
      return w;
   endfunction

   function automatic bit ref_legal(input logic [2:0] op, input logic [5:0] f_fn);
      bit fn_ok;
`ifdef INSTR_ENC_FUNCT_CHECK_EN
      fn_ok = (f_fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A});
`else
      fn_ok = (f_fn == f_fn);
`endif
      if (op == 3'd7) return 1'b0;
      if (op == 3'd0) return fn_ok;
      return 1'b1;
   endfunction

   task automatic modelReset();
      m_q.delete();
      m_writes = 0;
      m_count  = 16'h0;
      m_err    = 1'b0;
   endtask

   // Advances the model by one clock edge using the inputs currently driven.
   task automatic modelEdge();
      bit was_full;
      bit do_pop;
      bit acc;
      if (clear) begin
         modelReset();
      end else begin
         was_full = (m_q.size() == DEPTH);
         do_pop   = (m_q.size() != 0) && im_ready;
         acc      = req_valid && !was_full;
         if (do_pop) begin
            void'(m_q.pop_front());
            m_writes++;
            if (m_count != 16'hFFFF) m_count = m_count + 16'd1;
         end
         if (acc) begin
            if (ref_legal(op_sel, funct))
               m_q.push_back(ref_word(op_sel, rs, rt, rd, shamt, funct, imm));
            else
               m_err = 1'b1;
         end
      end
   endtask

   task automatic cmp(input string nm, input string fld, input logic [31:0] got,
                      input logic [31:0] exp);
      if (got !== exp) begin
         $display("[TB] FAIL %s.%s got=0x%0h exp=0x%0h", nm, fld, got, exp);
         cur_bad = 1'b1;
      end
   endtask

   // Compares both instances against the reference model.
   task automatic checkOutput(input string nm);
      logic [31:0] e_head;
      bit          e_full;
      cur_bad = 1'b0;
      e_full  = (m_q.size() == DEPTH);
      e_head  = (m_q.size() != 0) ? m_q[0] : 32'h0;
      cmp(nm, "we",      32'(im_we),      32'(m_q.size() != 0));
      cmp(nm, "addr",    32'(im_addr),    32'((4 * m_writes) % 1024));
      cmp(nm, "count",   32'(count),      32'(m_count));
      cmp(nm, "err",     32'(err),        32'(m_err));
      cmp(nm, "full",    32'(full),       32'(e_full));
      cmp(nm, "empty",   32'(empty),      32'(m_q.size() == 0));
      cmp(nm, "ready",   32'(req_ready),  32'(!e_full && !clear));
      cmp(nm, "s_we",    32'(s_im_we),    32'(m_q.size() != 0));
      cmp(nm, "s_addr",  32'(s_im_addr),  32'((4 * m_writes) % 16));
      cmp(nm, "s_count", 32'(s_count),    32'(m_count));
      cmp(nm, "s_err",   32'(s_err),      32'(m_err));
      cmp(nm, "s_full",  32'(s_full),     32'(e_full));
      cmp(nm, "s_empty", 32'(s_empty),    32'(m_q.size() == 0));
      cmp(nm, "s_ready", 32'(s_req_ready), 32'(!e_full && !clear));
      if (m_q.size() != 0) begin
         cmp(nm, "data",   im_data,   e_head);
         cmp(nm, "s_data", s_im_data, e_head);
      end
      vectors++;
      if (cur_bad) miscompares++;
   endtask

   task automatic setInputs(input vec_t v);
      req_valid = v.valid;
      op_sel    = v.op;
      rs        = v.rs;
      rt        = v.rt;
      rd        = v.rd;
      shamt     = v.sh;
      funct     = v.fn;
      imm       = v.imm;
      im_ready  = v.rdy;
      clear     = v.clr;
   endtask

   // Drives one cycle of inputs away from the edge, then samples 1 ns after it.
   task automatic applyStimulus(input vec_t v);
      @(negedge clk);
      setInputs(v);
      modelEdge();
      @(posedge clk);
      #1;
   endtask

   function automatic vec_t mkReq(input bit valid, input logic [2:0] op,
                                  input logic [15:0] f_imm, input bit rdy, input bit clr);
      vec_t v;
      v        = tbl[0];
      v.valid  = valid;
      v.op     = op;
      v.rs     = 5'(op) + 5'd1;
      v.rt     = 5'(op) + 5'd9;
      v.rd     = 5'd3;
      v.sh     = 5'd0;
      v.fn     = 6'h22;
      v.imm    = f_imm;
      v.rdy    = rdy;
      v.clr    = clr;
      return v;
   endfunction

   function automatic vec_t mkRandom();
      vec_t v;
      v       = tbl[0];
      v.valid = ($urandom_range(0, 9) < 7);
      v.op    = 3'($urandom_range(0, 7));
      v.rs    = 5'($urandom);
      v.rt    = 5'($urandom);
      v.rd    = 5'($urandom);
      v.sh    = 5'($urandom);
      v.fn    = ($urandom_range(0, 1) == 0) ? LEGAL_FN[$urandom_range(0, 4)] : 6'($urandom);
      v.imm   = 16'($urandom);
      v.rdy   = ($urandom_range(0, 9) < 6);
      v.clr   = ($urandom_range(0, 99) < 2);
      return v;
   endfunction

   initial begin
      //          valid op    rs     rt     rd     sh     fn     imm       rdy  clr  we   addr     data           cnt     err  full
      tbl[0]  = '{1'b1, 3'd1, 5'd1,  5'd2,  5'd31, 5'd31, 6'h3F, 16'h0005, 1'b1, 1'b0, 1'b1, 10'h000, 32'h20220005, 16'd0, 1'b0, 1'b0};
      tbl[1]  = '{1'b1, 3'd0, 5'd1,  5'd2,  5'd3,  5'd0,  6'h20, 16'hBEEF, 1'b1, 1'b0, 1'b1, 10'h004, 32'h00221820, 16'd1, 1'b0, 1'b0};
      tbl[2]  = '{1'b1, 3'd6, 5'd7,  5'd4,  5'd0,  5'd0,  6'h00, 16'h1234, 1'b1, 1'b0, 1'b1, 10'h008, 32'h3C041234, 16'd2, 1'b0, 1'b0};
      tbl[3]  = '{1'b1, 3'd4, 5'd1,  5'd2,  5'd0,  5'd0,  6'h00, 16'hFFFF, 1'b1, 1'b0, 1'b1, 10'h00C, 32'h1022FFFF, 16'd3, 1'b0, 1'b0};
      tbl[4]  = '{1'b0, 3'd0, 5'd0,  5'd0,  5'd0,  5'd0,  6'h00, 16'h0000, 1'b1, 1'b0, 1'b0, 10'h010, 32'h00000000, 16'd4, 1'b0, 1'b0};
      tbl[5]  = '{1'b1, 3'd7, 5'd5,  5'd5,  5'd5,  5'd0,  6'h20, 16'h5555, 1'b1, 1'b0, 1'b0, 10'h010, 32'h00000000, 16'd4, 1'b1, 1'b0};
      tbl[6]  = '{1'b1, 3'd1, 5'd0,  5'd1,  5'd0,  5'd0,  6'h00, 16'h0001, 1'b0, 1'b0, 1'b1, 10'h010, 32'h20010001, 16'd4, 1'b1, 1'b0};
      tbl[7]  = '{1'b1, 3'd2, 5'd2,  5'd3,  5'd0,  5'd0,  6'h00, 16'h00FF, 1'b0, 1'b0, 1'b1, 10'h010, 32'h20010001, 16'd4, 1'b1, 1'b0};
      tbl[8]  = '{1'b1, 3'd5, 5'd4,  5'd5,  5'd0,  5'd0,  6'h00, 16'h8000, 1'b0, 1'b0, 1'b1, 10'h010, 32'h20010001, 16'd4, 1'b1, 1'b0};
      tbl[9]  = '{1'b1, 3'd3, 5'd6,  5'd7,  5'd0,  5'd0,  6'h00, 16'h0010, 1'b0, 1'b0, 1'b1, 10'h010, 32'h20010001, 16'd4, 1'b1, 1'b1};
      tbl[10] = '{1'b1, 3'd1, 5'd1,  5'd1,  5'd0,  5'd0,  6'h00, 16'h0002, 1'b0, 1'b0, 1'b1, 10'h010, 32'h20010001, 16'd4, 1'b1, 1'b1};
      tbl[11] = '{1'b1, 3'd1, 5'd1,  5'd1,  5'd0,  5'd0,  6'h00, 16'h0002, 1'b1, 1'b0, 1'b1, 10'h014, 32'h344300FF, 16'd5, 1'b1, 1'b0};
      tbl[12] = '{1'b1, 3'd1, 5'd1,  5'd1,  5'd0,  5'd0,  6'h00, 16'h0002, 1'b1, 1'b0, 1'b1, 10'h018, 32'h28858000, 16'd6, 1'b1, 1'b0};
      tbl[13] = '{1'b0, 3'd0, 5'd0,  5'd0,  5'd0,  5'd0,  6'h00, 16'h0000, 1'b1, 1'b0, 1'b1, 10'h01C, 32'h14C70010, 16'd7, 1'b1, 1'b0};
      tbl[14] = '{1'b0, 3'd0, 5'd0,  5'd0,  5'd0,  5'd0,  6'h00, 16'h0000, 1'b1, 1'b0, 1'b1, 10'h020, 32'h20210002, 16'd8, 1'b1, 1'b0};
      tbl[15] = '{1'b0, 3'd0, 5'd0,  5'd0,  5'd0,  5'd0,  6'h00, 16'h0000, 1'b1, 1'b0, 1'b0, 10'h024, 32'h00000000, 16'd9, 1'b1, 1'b0};

      rst_n = 1'b0;
      setInputs(tbl[4]);
      im_ready = 1'b0;
      modelReset();
      #12;
      checkOutput("in_reset");
      cur_bad = 1'b0;
      cmp("in_reset", "data_zero", im_data, 32'h0);
      vectors++;
      if (cur_bad) miscompares++;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checkOutput("after_reset");

      // Directed table: encoding, latency, illegal op, full/backpressure.
      for (int i = 0; i < 16; i++) begin
         applyStimulus(tbl[i]);
         checkOutput($sformatf("tbl%0d_model", i));
         cur_bad = 1'b0;
         cmp($sformatf("tbl%0d", i), "we",    32'(im_we),   32'(tbl[i].e_we));
         cmp($sformatf("tbl%0d", i), "addr",  32'(im_addr), 32'(tbl[i].e_addr));
         cmp($sformatf("tbl%0d", i), "count", 32'(count),   32'(tbl[i].e_cnt));
         cmp($sformatf("tbl%0d", i), "err",   32'(err),     32'(tbl[i].e_err));
         cmp($sformatf("tbl%0d", i), "full",  32'(full),    32'(tbl[i].e_full));
         if (tbl[i].e_we) cmp($sformatf("tbl%0d", i), "data", im_data, tbl[i].e_data);
         vectors++;
         if (cur_bad) miscompares++;
      end

      // Clear with three words queued and a request pending.
      applyStimulus(mkReq(1'b1, 3'd1, 16'h0101, 1'b0, 1'b0));
      checkOutput("clr_fill0");
      applyStimulus(mkReq(1'b1, 3'd2, 16'h0202, 1'b0, 1'b0));
      checkOutput("clr_fill1");
      applyStimulus(mkReq(1'b1, 3'd5, 16'h0303, 1'b0, 1'b0));
      checkOutput("clr_fill2");
      applyStimulus(mkReq(1'b1, 3'd4, 16'h0404, 1'b1, 1'b1));
      checkOutput("clr_edge");
      cur_bad = 1'b0;
      cmp("clr_edge", "empty", 32'(empty),   32'h1);
      cmp("clr_edge", "addr",  32'(im_addr), 32'h0);
      cmp("clr_edge", "count", 32'(count),   32'h0);
      cmp("clr_edge", "err",   32'(err),     32'h0);
      vectors++;
      if (cur_bad) miscompares++;
      applyStimulus(mkReq(1'b0, 3'd4, 16'h0404, 1'b1, 1'b0));
      checkOutput("clr_after");

      // Reset asserted mid-drain must act immediately, without a clock edge.
      applyStimulus(mkReq(1'b1, 3'd1, 16'h0A0A, 1'b0, 1'b0));
      checkOutput("rst_fill0");
      applyStimulus(mkReq(1'b1, 3'd6, 16'h0B0B, 1'b0, 1'b0));
      checkOutput("rst_fill1");
      applyStimulus(mkReq(1'b1, 3'd2, 16'h0C0C, 1'b1, 1'b0));
      checkOutput("rst_drain");
      #2;
      rst_n = 1'b0;
      modelReset();
      #1;
      checkOutput("rst_async");
      cur_bad = 1'b0;
      cmp("rst_async", "data_zero", im_data, 32'h0);
      vectors++;
      if (cur_bad) miscompares++;
      @(negedge clk);
      req_valid = 1'b0;
      rst_n     = 1'b1;
      #1;
      checkOutput("rst_release");

      // Randomized traffic against the reference model.
      for (int n = 0; n < 600; n++) begin
         applyStimulus(mkRandom());
         checkOutput($sformatf("rand%0d", n));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Inverse of the control decoder: takes decoded instruction fields (class, registers, immediate) and packs them into 32-bit MIPS words.
- Buffers the encoded words in a small FIFO.
- Drains the FIFO into the instruction-memory write port at consecutive word addresses.
- Used as the bench/boot-time program loader in front of Instr_Memory.

Parameters:
- DEPTH, 4, FIFO entries; power of 2, at least 2.
- ADDR_W, 10, width of the byte address driven to instruction memory.
- BASE_ADDR, 0, first byte address written after reset or clear; must be a multiple of 4.

Ports:
- clk_i  in  1  single clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-low.
- clear_i  in  1  synchronous flush: empties FIFO, reloads address, zeroes count and err.
- req_valid_i  in  1  request field bundle valid.
- req_ready_o  out  1  encoder can accept a request this cycle.
- op_sel_i  in  3  class: 0 R-type, 1 ADDI, 2 ORI, 3 BNE, 4 BEQ, 5 SLTI, 6 LUI, 7 illegal.
- rs_i / rt_i / rd_i / shamt_i  in  5 each  register and shift fields.
- funct_i  in  6  R-type function field.
- imm_i  in  16  I-type immediate.
- im_ready_i  in  1  memory accepts the write this cycle.
- im_we_o  out  1  write request (FIFO not empty).
- im_addr_o  out  ADDR_W  byte address of the current write.
- im_data_o  out  32  encoded word at FIFO head.
- count_o  out  16  words written since reset or clear; saturates at 0xFFFF.
- err_o  out  1  sticky: an illegal request was seen.
- full_o / empty_o  out  1 each  FIFO status.

Behaviour:
- Reset (rst_i low, async):
  - FIFO empty; im_we_o=0, im_data_o=0; im_addr_o=BASE_ADDR; count_o=0; err_o=0.
  - empty_o=1, full_o=0, req_ready_o=1 once rst_i is released.
  - FIFO contents are discarded when reset asserts mid-drain.
- Accept and encode:
  - req_ready_o = !full_o && !clear_i.
  - A push happens on an edge with req_valid_i && req_ready_o.
  - Opcode map: 0→0x00, 1→0x08, 2→0x0D, 3→0x05, 4→0x04, 5→0x0A, 6→0x0F.
  - R-type word: {6'h00, rs, rt, rd, shamt, funct}.
  - I-type word: {op, rs, rt, imm}.
  - LUI forces the rs field to 0.
  - Unused input fields are ignored.
- Illegal request (op_sel_i=7): handshake completes, nothing is enqueued, err_o is set to 1 on that edge.
- Drain:
  - im_we_o = !empty_o; im_data_o = FIFO head.
  - On an edge with im_we_o && im_ready_i: pop; im_addr_o += 4 (wraps modulo 2^ADDR_W); count_o += 1 (saturating).
  - im_we_o, im_addr_o and im_data_o are held stable while im_ready_i is low.
- Latency: a word pushed at edge N is visible on im_we_o/im_data_o in cycle N+1 at the earliest. There is no same-cycle bypass.
- Simultaneous push and pop:
  - When partly full: both occur and the occupancy is unchanged.
  - When full: only the pop occurs, since ready is low while full.
  - When empty: only the push occurs.
- Ordering: strict FIFO. Words reach memory in acceptance order at strictly increasing addresses.
- clear_i has priority over push and pop on the same edge:
  - FIFO emptied, im_addr_o=BASE_ADDR, count_o=0, err_o=0.
  - No memory write is counted on that edge.
- Pointers: log2(DEPTH)+1 bits. full when the MSBs differ and the remaining bits are equal; empty when the pointers are equal.

Optional Feature:
- Macro: INSTR_ENC_FUNCT_CHECK_EN.
- When defined, R-type requests are accepted only for funct ∈ {0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt}.
  - Any other funct is treated as illegal: handshake completes, nothing is enqueued, err_o is set.
- When undefined, every R-type funct is encoded and enqueued unchecked.

Test Plan:
- Reset, then ADDI rs=1 rt=2 imm=0x0005 with im_ready_i=1 → one cycle later im_we_o=1, im_addr_o=0x000, im_data_o=0x20220005; count_o=1 after the edge.
- Back-to-back R-type (rs=1 rt=2 rd=3 funct=0x20), LUI (rt=4 imm=0x1234, rs_i=7), BEQ (rs=1 rt=2 imm=0xFFFF) → writes 0x00221820 @0x000, 0x3C041234 @0x004, 0x1022FFFF @0x008.
- Hold im_ready_i=0 and push 5 requests with DEPTH=4:
  - Expect full_o=1 and req_ready_o=0 after the 4th; the 5th is held off.
  - Raise im_ready_i → 5 words drain in order and count_o=5.
- op_sel_i=7 between two valid requests → err_o=1, only 2 words written, at consecutive addresses.
- With 3 words queued, assert clear_i with req_valid_i=1 → empty_o=1, im_addr_o=BASE_ADDR, count_o=0, err_o=0, and the request is not accepted.
- ADDR_W=4, 5 writes from BASE_ADDR=0 → addresses 0x0, 0x4, 0x8, 0xC, 0x0 (wrap). Repeat with rst_i pulsed low mid-drain → outputs return to their reset values immediately.
